// File: rtl/debug_slave_cmd_sequencer.sv
// System-clock side of the JTAG debug slave: syncs TCK update strobes, captures the scan
// register and sequences single-word OCI memory accesses with timeout and overrun tracking.
module debug_slave_cmd_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [1:0]        ir_in,
  input  logic [37:0]       sr,
  output logic [37:0]       jdo,
  output logic              take_action_break,
  output logic              take_action_tracectrl,
  output logic              ocimem_req,
  output logic              ocimem_wr,
  output logic [ADDR_W-1:0] ocimem_addr,
  output logic [31:0]       ocimem_wdata,
  input  logic              ocimem_ack,
  input  logic [31:0]       ocimem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_prev, uir_prev;
  logic                   udr_p, uir_p;
  logic                   act_p;
  logic [1:0]             ir_q;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            wdata_q;

  logic [1:0] op;
  logic       ocimem_cmd, cmd_accept, start, ack_hit, timeout_hit, nop_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      udr_p    <= 1'b0;
      uir_p    <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
      udr_p    <= udr_sync[SYNC_STAGES-1] & ~udr_prev;
      uir_p    <= uir_sync[SYNC_STAGES-1] & ~uir_prev;
    end
  end

  assign op          = sr[37:36];
  assign ocimem_cmd  = udr_p && (ir_in == 2'b00);
  assign cmd_accept  = ocimem_cmd && (state == IDLE);
  assign start       = cmd_accept && op[1];
  assign nop_clear   = cmd_accept && (op == 2'b00) && sr[0];
  assign ack_hit     = (state == REQ) && ocimem_ack;
  // Count holds completed REQ cycles, so the last allowed cycle sees TIMEOUT_CYC-1.
  assign timeout_hit = (state == REQ) && !ocimem_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ocimem_req    = 1'b0;
    monitor_ready = 1'b0;
    case (state)
      IDLE: begin
        monitor_ready = 1'b1;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        ocimem_req = 1'b1;
        if (ack_hit || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo           <= '0;
      ir_q          <= '0;
      act_p         <= 1'b0;
      ocimem_wr     <= 1'b0;
      ocimem_addr   <= '0;
      wdata_q       <= '0;
      MonDReg       <= '0;
      cnt           <= '0;
      monitor_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      act_p <= udr_p;
      if (udr_p) begin
        jdo  <= sr;
        ir_q <= ir_in;
      end
      if (start) begin
        ocimem_wr <= ~op[0];
        wdata_q   <= sr[31:0];
        cnt       <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cmd_accept && (op == 2'b01)) ocimem_addr <= sr[ADDR_W-1:0];
      else if (ack_hit)                ocimem_addr <= ocimem_addr + ADDR_W'(1);
      if (ack_hit && !ocimem_wr) MonDReg <= ocimem_rdata;
      if (timeout_hit)    monitor_error <= 1'b1;
      else if (nop_clear) monitor_error <= 1'b0;
      // A busy-time command is lost, so a new overrun must win over any same-cycle clear.
      if (ocimem_cmd && (state == REQ)) overrun <= 1'b1;
      else if (uir_p || nop_clear)      overrun <= 1'b0;
    end
  end

  assign take_action_break     = act_p && (ir_q == 2'b10);
  assign take_action_tracectrl = act_p && (ir_q == 2'b01);
  assign ocimem_wdata          = wdata_q;

endmodule

// File: tb/tb_debug_slave_cmd_sequencer.sv
// Directed bench for debug_slave_cmd_sequencer with hand-computed expectations (TIMEOUT_CYC=4).
module tb_debug_slave_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic [1:0]  ir_in = 2'b00;
  logic [37:0] sr = '0;
  logic [37:0] jdo;
  logic        take_action_break, take_action_tracectrl;
  logic        ocimem_req, ocimem_wr;
  logic [7:0]  ocimem_addr;
  logic [31:0] ocimem_wdata;
  logic        ocimem_ack = 1'b0;
  logic [31:0] ocimem_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, overrun;

  int n_chk = 0;
  int n_fail = 0;

  debug_slave_cmd_sequencer #(.ADDR_W(8), .TIMEOUT_CYC(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .jdo(jdo), .take_action_break(take_action_break), .take_action_tracectrl(take_action_tracectrl),
    .ocimem_req(ocimem_req), .ocimem_wr(ocimem_wr), .ocimem_addr(ocimem_addr),
    .ocimem_wdata(ocimem_wdata), .ocimem_ack(ocimem_ack), .ocimem_rdata(ocimem_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Returns in the cycle after the synchronised udr pulse (pulse cycle N, returns at N+1).
  task automatic send(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick();
    vs_udr = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic send_uir();
    vs_uir = 1'b1;
    tick();
    vs_uir = 1'b0;
    tick();
    tick();
    tick();
  endtask

  function automatic logic [37:0] cmd(input logic [1:0] op, input logic [31:0] d);
    return {op, 4'h0, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_jdo", jdo, 0);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_addr", ocimem_addr, 0);
    chk("rst_req", ocimem_req, 0);
    chk("rst_wr", ocimem_wr, 0);
    chk("rst_ready", monitor_ready, 1);
    chk("rst_error", monitor_error, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_break", take_action_break, 0);
    reset_n = 1'b1;
    tick();
    tick();

    // SETADDR 0x10
    send(2'b00, cmd(2'b01, 32'h10));
    chk("setaddr_addr", ocimem_addr, 8'h10);
    chk("setaddr_req", ocimem_req, 0);
    chk("setaddr_jdo", jdo, cmd(2'b01, 32'h10));
    tick();
    chk("setaddr_req2", ocimem_req, 0);

    // WRITE 0xDEADBEEF, ack in the third REQ cycle
    send(2'b00, cmd(2'b10, 32'hDEADBEEF));
    chk("wr_req_c1", ocimem_req, 1);
    chk("wr_wr", ocimem_wr, 1);
    chk("wr_addr", ocimem_addr, 8'h10);
    chk("wr_wdata", ocimem_wdata, 32'hDEADBEEF);
    chk("wr_ready_busy", monitor_ready, 0);
    tick();
    chk("wr_req_c2", ocimem_req, 1);
    tick();
    chk("wr_req_c3", ocimem_req, 1);
    ocimem_ack = 1'b1;
    tick();
    ocimem_ack = 1'b0;
    chk("wr_req_done", ocimem_req, 0);
    chk("wr_addr_inc", ocimem_addr, 8'h11);
    chk("wr_ready_done", monitor_ready, 1);

    // READ at 0xFF with address wrap
    send(2'b00, cmd(2'b01, 32'hFF));
    chk("rd_setaddr", ocimem_addr, 8'hFF);
    send(2'b00, cmd(2'b11, 32'h0));
    chk("rd_req", ocimem_req, 1);
    chk("rd_wr", ocimem_wr, 0);
    ocimem_ack = 1'b1;
    ocimem_rdata = 32'h12345678;
    tick();
    ocimem_ack = 1'b0;
    ocimem_rdata = 32'h0;
    chk("rd_mondreg", MonDReg, 32'h12345678);
    chk("rd_addr_wrap", ocimem_addr, 8'h00);
    chk("rd_error", monitor_error, 0);

    // READ with ack withheld: exactly 4 REQ cycles then timeout
    send(2'b00, cmd(2'b11, 32'h0));
    chk("to_req_c1", ocimem_req, 1);
    tick();
    chk("to_req_c2", ocimem_req, 1);
    tick();
    chk("to_req_c3", ocimem_req, 1);
    tick();
    chk("to_req_c4", ocimem_req, 1);
    chk("to_error_pre", monitor_error, 0);
    tick();
    chk("to_req_drop", ocimem_req, 0);
    chk("to_error", monitor_error, 1);
    chk("to_addr", ocimem_addr, 8'h00);
    chk("to_mondreg", MonDReg, 32'h12345678);
    send(2'b00, cmd(2'b00, 32'h1));
    chk("nop_clr_error", monitor_error, 0);

    // Overrun: second OCIMEM udr lands in REQ cycle 4, ack in that same cycle wins
    send(2'b00, cmd(2'b10, 32'hA5A55A5A));
    chk("ov_req", ocimem_req, 1);
    fork
      send(2'b00, cmd(2'b10, 32'h11112222));
      begin
        tick();
        tick();
        tick();
        ocimem_ack = 1'b1;
        tick();
        ocimem_ack = 1'b0;
      end
    join
    chk("ov_overrun", overrun, 1);
    chk("ov_wdata", ocimem_wdata, 32'hA5A55A5A);
    chk("ov_addr", ocimem_addr, 8'h01);
    chk("ov_error_ackwins", monitor_error, 0);
    chk("ov_jdo", jdo, cmd(2'b10, 32'h11112222));
    chk("ov_req_idle", ocimem_req, 0);
    tick();
    chk("ov_no_restart", ocimem_req, 0);
    ocimem_ack = 1'b1;
    tick();
    ocimem_ack = 1'b0;
    tick();
    chk("idle_ack_addr", ocimem_addr, 8'h01);
    chk("idle_ack_mondreg", MonDReg, 32'h12345678);
    send_uir();
    chk("uir_clr_overrun", overrun, 0);
    chk("uir_ready", monitor_ready, 1);

    // BREAK during REQ
    send(2'b00, cmd(2'b10, 32'h0BAD0BAD));
    chk("brk_req", ocimem_req, 1);
    send(2'b10, cmd(2'b00, 32'h55));
    chk("brk_pulse", take_action_break, 1);
    chk("brk_trace", take_action_tracectrl, 0);
    chk("brk_overrun", overrun, 0);
    tick();
    chk("brk_pulse_end", take_action_break, 0);
    chk("brk_timeout_err", monitor_error, 1);
    send(2'b00, cmd(2'b00, 32'h1));
    chk("nop_clr_error2", monitor_error, 0);

    // TRACE and ir=11
    send(2'b01, cmd(2'b10, 32'h77));
    chk("trc_pulse", take_action_tracectrl, 1);
    chk("trc_req", ocimem_req, 0);
    tick();
    chk("trc_pulse_end", take_action_tracectrl, 0);
    send(2'b11, cmd(2'b11, 32'hCAFEF00D));
    chk("ir3_jdo", jdo, cmd(2'b11, 32'hCAFEF00D));
    chk("ir3_req", ocimem_req, 0);
    chk("ir3_break", take_action_break, 0);
    chk("ir3_trace", take_action_tracectrl, 0);

    // Async reset mid-REQ, late ack ignored
    send(2'b00, cmd(2'b11, 32'h0));
    chk("ar_req", ocimem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req_now", ocimem_req, 0);
    chk("ar_ready_now", monitor_ready, 1);
    chk("ar_mondreg_now", MonDReg, 0);
    chk("ar_addr_now", ocimem_addr, 0);
    tick();
    reset_n = 1'b1;
    tick();
    ocimem_ack = 1'b1;
    ocimem_rdata = 32'hFFFF0000;
    tick();
    ocimem_ack = 1'b0;
    chk("ar_late_ack_mondreg", MonDReg, 0);
    chk("ar_late_ack_req", ocimem_req, 0);
    chk("ar_late_ack_addr", ocimem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
